// File: rtl/snake_motion_core.sv
// snake_motion_core: segment store, direction, lives and length for one snake.
// Each accepted step runs CALC -> SCAN (serial self-collision check) -> COMMIT.
// The renderer reads segments through a registered port indexed from the head.
module snake_motion_core #(
   parameter int COORD_WIDTH  = 10,
   parameter int MAX_LENGTH   = 64,
   parameter int LENGTH_WIDTH = 7,
   parameter int GRID_W       = 64,
   parameter int GRID_H       = 48,
   parameter int WRAP_MODE    = 0,
   parameter int INIT_LENGTH  = 3,
   parameter int INIT_LIVES   = 3,
   parameter int START_X      = 10,
   parameter int START_Y      = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    step,
   input  logic [1:0]              dir_in,
   input  logic                    grow,
   input  logic                    shrink,
   input  logic [LENGTH_WIDTH-1:0] rd_idx,
   output logic [COORD_WIDTH-1:0]  rd_x,
   output logic [COORD_WIDTH-1:0]  rd_y,
   output logic [COORD_WIDTH-1:0]  head_x,
   output logic [COORD_WIDTH-1:0]  head_y,
   output logic [LENGTH_WIDTH-1:0] length,
   output logic [2:0]              lives,
   output logic                    busy,
   output logic                    done,
   output logic                    collision,
   output logic                    game_over
);

   typedef enum logic [2:0] {IDLE, CALC, SCAN, COMMIT, DEAD} state_t;

   state_t                  state;
   logic [COORD_WIDTH-1:0]  body_x [MAX_LENGTH];
   logic [COORD_WIDTH-1:0]  body_y [MAX_LENGTH];
   logic [1:0]              dir;
   logic [COORD_WIDTH-1:0]  nxt_x, nxt_y;
   logic                    hit;
   logic                    grow_pend, shrink_pend;
   logic [LENGTH_WIDTH-1:0] idx;

   logic [COORD_WIDTH-1:0]  calc_x, calc_y;
   logic                    calc_wall;
   logic [COORD_WIDTH-1:0]  seg_x, seg_y, rseg_x, rseg_y;
   logic [LENGTH_WIDTH-1:0] last_idx;
   logic                    tail_live, cmp_en, scan_hit, scan_end;

   assign head_x = body_x[0];
   assign head_y = body_y[0];
   assign busy   = (state == CALC) || (state == SCAN) || (state == COMMIT);

   // Next head from the current head and direction; edges either wrap or flag a wall.
   always_comb begin
      calc_x    = body_x[0];
      calc_y    = body_y[0];
      calc_wall = 1'b0;
      case (dir)
         2'd0: if (body_y[0] == '0) begin
                  calc_y    = COORD_WIDTH'(GRID_H - 1);
                  calc_wall = (WRAP_MODE == 0);
               end else calc_y = body_y[0] - 1'b1;
         2'd1: if (body_x[0] == COORD_WIDTH'(GRID_W - 1)) begin
                  calc_x    = '0;
                  calc_wall = (WRAP_MODE == 0);
               end else calc_x = body_x[0] + 1'b1;
         2'd2: if (body_y[0] == COORD_WIDTH'(GRID_H - 1)) begin
                  calc_y    = '0;
                  calc_wall = (WRAP_MODE == 0);
               end else calc_y = body_y[0] + 1'b1;
         default: if (body_x[0] == '0) begin
                  calc_x    = COORD_WIDTH'(GRID_W - 1);
                  calc_wall = (WRAP_MODE == 0);
               end else calc_x = body_x[0] - 1'b1;
      endcase
   end

   // Segment muxes for the scan compare and the read port (full-width index match).
   always_comb begin
      seg_x  = '0;
      seg_y  = '0;
      rseg_x = '0;
      rseg_y = '0;
      for (int k = 0; k < MAX_LENGTH; k++) begin
         if (idx == LENGTH_WIDTH'(k)) begin
            seg_x = body_x[k];
            seg_y = body_y[k];
         end
         if (rd_idx == LENGTH_WIDTH'(k)) begin
            rseg_x = body_x[k];
            rseg_y = body_y[k];
         end
      end
   end

   // The tail vacates its cell on a normal move, so it only counts when it is retained.
   assign tail_live = grow_pend && (length < LENGTH_WIDTH'(MAX_LENGTH));
   assign last_idx  = length - LENGTH_WIDTH'(1);
   assign cmp_en    = (idx < length) && ((idx != last_idx) || tail_live);
   assign scan_hit  = cmp_en && (seg_x == nxt_x) && (seg_y == nxt_y);
   assign scan_end  = (idx >= last_idx);

   // Move FSM plus all snake state; every update lands on the COMMIT edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         dir         <= 2'd1;
         length      <= LENGTH_WIDTH'(INIT_LENGTH);
         lives       <= 3'(INIT_LIVES);
         done        <= 1'b0;
         collision   <= 1'b0;
         game_over   <= 1'b0;
         grow_pend   <= 1'b0;
         shrink_pend <= 1'b0;
         hit         <= 1'b0;
         idx         <= '0;
         nxt_x       <= '0;
         nxt_y       <= '0;
         for (int i = 0; i < MAX_LENGTH; i++) begin
            body_x[i] <= (i < INIT_LENGTH) ? COORD_WIDTH'(START_X - i) : '0;
            body_y[i] <= (i < INIT_LENGTH) ? COORD_WIDTH'(START_Y) : '0;
         end
      end else begin
         done      <= 1'b0;
         collision <= 1'b0;
         if (state != DEAD) begin
            if (grow)   grow_pend   <= 1'b1;
            if (shrink) shrink_pend <= 1'b1;
         end
         case (state)
            IDLE: if (step) begin
               if (dir_in != (dir ^ 2'd2)) dir <= dir_in;
               state <= CALC;
            end
            CALC: begin
               nxt_x <= calc_x;
               nxt_y <= calc_y;
               hit   <= calc_wall;
               idx   <= LENGTH_WIDTH'(1);
               state <= calc_wall ? COMMIT : SCAN;
            end
            SCAN: begin
               if (scan_hit) begin
                  hit   <= 1'b1;
                  state <= COMMIT;
               end else if (scan_end) state <= COMMIT;
               else idx <= idx + LENGTH_WIDTH'(1);
            end
            COMMIT: begin
               done <= 1'b1;
               if (hit) begin
                  collision   <= 1'b1;
                  lives       <= lives - 3'd1;
                  grow_pend   <= 1'b0;
                  shrink_pend <= 1'b0;
                  if (lives <= 3'd1) begin
                     state     <= DEAD;
                     game_over <= 1'b1;
                  end else begin
                     state  <= IDLE;
                     dir    <= 2'd1;
                     length <= LENGTH_WIDTH'(INIT_LENGTH);
                     for (int i = 0; i < MAX_LENGTH; i++) begin
                        if (i < INIT_LENGTH) begin
                           body_x[i] <= COORD_WIDTH'(START_X - i);
                           body_y[i] <= COORD_WIDTH'(START_Y);
                        end
                     end
                  end
               end else begin
                  state       <= IDLE;
                  grow_pend   <= grow;
                  shrink_pend <= shrink;
                  for (int k = MAX_LENGTH - 1; k > 0; k--) begin
                     body_x[k] <= body_x[k-1];
                     body_y[k] <= body_y[k-1];
                  end
                  body_x[0] <= nxt_x;
                  body_y[0] <= nxt_y;
                  if (grow_pend && !shrink_pend) begin
                     if (length < LENGTH_WIDTH'(MAX_LENGTH)) length <= length + LENGTH_WIDTH'(1);
                  end else if (shrink_pend && !grow_pend && (length > LENGTH_WIDTH'(1))) begin
                     length <= length - LENGTH_WIDTH'(1);
                  end
               end
            end
            DEAD: begin
               grow_pend   <= 1'b0;
               shrink_pend <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Registered read port; sees pre-commit contents during COMMIT.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_x <= '0;
         rd_y <= '0;
      end else if (rd_idx < length) begin
         rd_x <= rseg_x;
         rd_y <= rseg_y;
      end else begin
         rd_x <= '0;
         rd_y <= '0;
      end
   end

endmodule

// File: tb/tb_snake_motion_core.sv
// Bench for snake_motion_core: a queue-based snake model checked every cycle,
// plus directed moves with hand-computed literal expectations.
module tb_snake_motion_core;
   localparam int CW = 10, ML = 64, LW = 7, GW = 64, GH = 48;
   localparam int IL = 3, ILV = 3, SX = 10, SY = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1, step, grow, shrink, sel, chk_en, rd_hold;
   logic [1:0] dir_in;
   logic [LW-1:0] rd_idx;
   logic [CW-1:0] rx0, ry0, hx0, hy0, rx1, ry1, hx1, hy1;
   logic [LW-1:0] len0, len1;
   logic [2:0] lv0, lv1;
   logic bz0, dn0, co0, go0, bz1, dn1, co1, go1;

   snake_motion_core #(.WRAP_MODE(0)) u0 (
      .clk(clk), .reset(rst0), .step(step), .dir_in(dir_in), .grow(grow), .shrink(shrink),
      .rd_idx(rd_idx), .rd_x(rx0), .rd_y(ry0), .head_x(hx0), .head_y(hy0), .length(len0),
      .lives(lv0), .busy(bz0), .done(dn0), .collision(co0), .game_over(go0));

   snake_motion_core #(.WRAP_MODE(1)) u1 (
      .clk(clk), .reset(rst1), .step(step), .dir_in(dir_in), .grow(grow), .shrink(shrink),
      .rd_idx(rd_idx), .rd_x(rx1), .rd_y(ry1), .head_x(hx1), .head_y(hy1), .length(len1),
      .lives(lv1), .busy(bz1), .done(dn1), .collision(co1), .game_over(go1));

   // Active DUT selection: phase 0 uses the walled instance, phase 1 the wrapping one.
   logic [CW-1:0] a_rx, a_ry, a_hx, a_hy;
   logic [LW-1:0] a_len;
   logic [2:0] a_lv;
   logic a_bz, a_dn, a_co, a_go, a_rst;
   assign a_rx = sel ? rx1 : rx0;   assign a_ry = sel ? ry1 : ry0;
   assign a_hx = sel ? hx1 : hx0;   assign a_hy = sel ? hy1 : hy0;
   assign a_len = sel ? len1 : len0; assign a_lv = sel ? lv1 : lv0;
   assign a_bz = sel ? bz1 : bz0;   assign a_dn = sel ? dn1 : dn0;
   assign a_co = sel ? co1 : co0;   assign a_go = sel ? go1 : go0;
   assign a_rst = sel ? rst1 : rst0;

   int checks = 0, errors = 0, cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int qx[$], qy[$];
   int m_dir, m_lives, m_cnt, p_nx, p_ny, e_rx, e_ry;
   bit m_go, m_dead, m_grow, m_shrink, p_hit, e_done, e_coll;

   function automatic void model_respawn();
      qx.delete(); qy.delete();
      for (int i = 0; i < IL; i++) begin qx.push_back(SX - i); qy.push_back(SY); end
      m_dir = 1;
   endfunction

   function automatic void model_reset();
      model_respawn();
      m_lives = ILV; m_cnt = 0; m_go = 0; m_dead = 0; m_grow = 0; m_shrink = 0;
      e_done = 0; e_coll = 0; e_rx = 0; e_ry = 0; p_hit = 0;
   endfunction

   function automatic void model_start(input int d);
      int nx, ny, L, lat;
      bit wall;
      if (d != (m_dir + 2) % 4) m_dir = d;
      nx = qx[0]; ny = qy[0];
      case (m_dir)
         0: ny--;
         1: nx++;
         2: ny++;
         default: nx--;
      endcase
      wall = 0;
      if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
         if (sel) begin nx = (nx + GW) % GW; ny = (ny + GH) % GH; end
         else wall = 1;
      end
      L = qx.size();
      p_hit = wall;
      if (wall) lat = 2;
      else begin
         lat = ((L < 2) ? 2 : L) + 1;
         for (int i = 1; i < L; i++) begin
            if (i == L - 1 && !(m_grow && L < ML)) continue;
            if (qx[i] == nx && qy[i] == ny) begin p_hit = 1; lat = i + 2; break; end
         end
      end
      p_nx = nx; p_ny = ny; m_cnt = lat;
   endfunction

   function automatic void model_commit();
      int L, nl;
      e_done = 1;
      if (p_hit) begin
         e_coll = 1; m_lives--; m_grow = 0; m_shrink = 0;
         if (m_lives == 0) begin m_dead = 1; m_go = 1; end
         else model_respawn();
      end else begin
         L = qx.size(); nl = L;
         if (m_grow && !m_shrink && L < ML) nl = L + 1;
         else if (m_shrink && !m_grow && L > 1) nl = L - 1;
         qx.push_front(p_nx); qy.push_front(p_ny);
         while (qx.size() > nl) begin void'(qx.pop_back()); void'(qy.pop_back()); end
         m_grow = 0; m_shrink = 0;
      end
   endfunction

   always @(posedge clk) begin
      if (!a_rst) model_reset();
      else begin
         if (rd_idx < qx.size()) begin e_rx = qx[rd_idx]; e_ry = qy[rd_idx]; end
         else begin e_rx = 0; e_ry = 0; end
         e_done = 0; e_coll = 0;
         if (!m_dead && grow)   m_grow = 1;
         if (!m_dead && shrink) m_shrink = 1;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) model_commit();
         end else if (!m_dead && step) model_start(dir_in);
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("head_x", a_hx, qx[0]);
         check("head_y", a_hy, qy[0]);
         check("length", a_len, qx.size());
         check("lives", a_lv, m_lives);
         check("game_over", a_go, m_go);
         check("busy", a_bz, m_cnt > 0);
         check("done", a_dn, e_done);
         check("collision", a_co, e_coll);
         check("rd_x", a_rx, e_rx);
         check("rd_y", a_ry, e_ry);
      end
   end

   // Background read-index sweep, including indices past the current length.
   always @(posedge clk) begin
      #2;
      if (!rd_hold) rd_idx = LW'(cyc % 7);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_step(input int d, input bit poke, output int lat, output bit coll);
      int t0, n;
      bit seen;
      tick(); step = 1'b1; dir_in = 2'(d);
      tick(); step = 1'b0; t0 = cyc;
      if (poke) begin step = 1'b1; tick(); step = 1'b0; end
      n = 0; seen = 0; lat = -1; coll = 0;
      while (!seen && n < 100) begin
         @(negedge clk); n++;
         if (a_dn) begin seen = 1; lat = cyc - t0; coll = a_co; end
      end
      if (!seen) begin
         errors++;
         $display("FAIL step_timeout actual=no_done expected=done (t=%0t)", $time);
      end
   endtask

   task automatic pulse_grow();
      tick(); grow = 1'b1; tick(); grow = 1'b0;
   endtask

   task automatic pulse_shrink();
      tick(); shrink = 1'b1; tick(); shrink = 1'b0;
   endtask

   task automatic read_seg(input int k, input int ex, input int ey);
      tick(); rd_hold = 1'b1; rd_idx = LW'(k);
      tick(); @(negedge clk);
      check($sformatf("seg%0d_x", k), a_rx, ex);
      check($sformatf("seg%0d_y", k), a_ry, ey);
      rd_hold = 1'b0;
   endtask

   int lat;
   bit coll;
   int body4_x[4] = '{13, 12, 11, 10};

   initial begin
      sel = 0; rst0 = 0; rst1 = 0; step = 0; grow = 0; shrink = 0; dir_in = 2'd1;
      rd_hold = 0; rd_idx = '0; chk_en = 0;
      tick(); chk_en = 1;
      tick();
      check("rst_head_x", a_hx, 10); check("rst_head_y", a_hy, 10);
      check("rst_length", a_len, 3); check("rst_lives", a_lv, 3);
      check("rst_busy", a_bz, 0);    check("rst_rd_x", a_rx, 0);
      rst0 = 1;

      // First move right
      do_step(1, 0, lat, coll);
      check("lat_first", lat, 4); check("head_x_first", a_hx, 11); check("len_first", a_len, 3);
      read_seg(2, 9, 10);
      // Reversal ignored, extra step while busy dropped
      do_step(3, 1, lat, coll);
      check("lat_rev", lat, 4); check("head_x_rev", a_hx, 12); check("head_y_rev", a_hy, 10);
      // Grow
      pulse_grow(); do_step(1, 0, lat, coll);
      check("len_grow", a_len, 4);
      for (int k = 0; k < 4; k++) read_seg(k, body4_x[k], 10);
      // Length 5 then U-turn into own body at index 3
      pulse_grow(); do_step(1, 0, lat, coll);
      check("len_five", a_len, 5); check("head_x_five", a_hx, 14);
      do_step(0, 0, lat, coll); check("lat_up_L5", lat, 6);
      do_step(3, 0, lat, coll);
      do_step(2, 0, lat, coll);
      check("lat_self_hit", lat, 5); check("coll_self_hit", coll, 1);
      check("lives_self_hit", a_lv, 2); check("head_x_respawn", a_hx, 10);
      check("len_respawn", a_len, 3);
      // Shrink down to the floor, cancel, then regrow
      pulse_shrink(); do_step(1, 0, lat, coll); check("len_shrink", a_len, 2);
      pulse_shrink(); do_step(1, 0, lat, coll); check("len_shrink1", a_len, 1);
      pulse_shrink(); do_step(1, 0, lat, coll);
      check("len_floor", a_len, 1); check("lat_len1", lat, 3);
      pulse_grow(); pulse_shrink(); do_step(1, 0, lat, coll); check("len_cancel", a_len, 1);
      pulse_grow(); do_step(1, 0, lat, coll); check("len_regrow", a_len, 2);
      // Run into the right wall
      for (int g = 0; g < 80 && qx[0] != GW - 1; g++) do_step(1, 0, lat, coll);
      do_step(1, 0, lat, coll);
      check("lat_wall", lat, 2); check("coll_wall", coll, 1); check("lives_wall", a_lv, 1);
      check("head_x_wall", a_hx, 10); check("len_wall", a_len, 3);

      // Phase 1: wrapping instance
      chk_en = 0; tick(); sel = 1; rst0 = 0; rst1 = 0;
      tick(); tick(); rst1 = 1; chk_en = 1;
      // Reset mid-move aborts without commit
      tick(); step = 1; dir_in = 2'd0; tick(); step = 0; tick(); tick();
      rst1 = 0; tick(); rst1 = 1;
      check("abort_head_y", a_hy, 10); check("abort_busy", a_bz, 0); check("abort_len", a_len, 3);
      for (int g = 0; g < 80 && qx[0] != GW - 1; g++) do_step(1, 0, lat, coll);
      do_step(1, 0, lat, coll);
      check("wrap_head_x", a_hx, 0); check("wrap_coll", coll, 0); check("wrap_lat", lat, 4);
      for (int r = 0; r < 3; r++) begin
         pulse_grow(); do_step(1, 0, lat, coll);
         pulse_grow(); do_step(1, 0, lat, coll);
         do_step(0, 0, lat, coll); do_step(3, 0, lat, coll); do_step(2, 0, lat, coll);
         check("wrap_uturn_coll", coll, 1);
      end
      check("dead_lives", a_lv, 0); check("dead_game_over", a_go, 1);
      tick(); step = 1; grow = 1; dir_in = 2'd1; tick(); step = 0; grow = 0;
      repeat (5) tick();
      check("dead_busy", a_bz, 0); check("dead_len", a_len, 5);
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
